tdc_reader: RTL

TDC_READER -- requirements
Module: tdc_reader

---
 rtl/tdc_pkg.sv | 13 +
 rtl/tdc_therm2bin.sv | 30 +++
 rtl/tdc_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared TDC definitions: reader FSM states and the delay-line length used by the sensor tile.
package tdc_pkg;

  localparam int TDC_N_DELAY = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_SAMPLE,
    ST_DONE
  } tdc_state_e;

endpackage

// File: rtl/tdc_therm2bin.sv
// Thermometer-to-binary decode: code is the index of the lowest 0 tap, bubble flags any 1 above it.
module tdc_therm2bin
  import tdc_pkg::*;
#(
  parameter int N_DELAY = TDC_N_DELAY
) (
  input  logic [N_DELAY-1:0]            taps,
  output logic [$clog2(N_DELAY+1)-1:0]  code,
  output logic                          bubble
);

  localparam int CW = $clog2(N_DELAY + 1);

  logic found;

  // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latch).
  always_comb begin
    code   = CW'(N_DELAY);
    bubble = 1'b0;
    found  = 1'b0;
    for (int i = 0; i < N_DELAY; i++) begin
      if (found && taps[i]) bubble = 1'b1;
      if (!found && !taps[i]) begin
        code  = CW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdc_reader.sv
// TDC reader: synchronizes tap code, averages 2^LOG2_SAMPLES decoded samples per start request.
// Optional min/max code outputs are enabled by defining TDC_READER_MINMAX_EN.
module tdc_reader
  import tdc_pkg::*;
#(
  parameter int N_DELAY      = TDC_N_DELAY,
  parameter int LOG2_SAMPLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_DELAY-1:0] taps,
  input  logic               start,
  input  logic               ack,
  output logic               busy,
  output logic               valid,
  output logic [7:0]         result,
  output logic               bubble_err
`ifdef TDC_READER_MINMAX_EN
  ,
  output logic [7:0]         code_min,
  output logic [7:0]         code_max
`endif
);

  localparam int CW   = $clog2(N_DELAY + 1);
  localparam int ACCW = CW + LOG2_SAMPLES;
  localparam int CNTW = LOG2_SAMPLES + 2;
  localparam logic [CNTW-1:0] SYNC_LAST   = CNTW'(2);
  localparam logic [CNTW-1:0] SAMPLE_LAST = CNTW'((1 << LOG2_SAMPLES) - 1);

  tdc_state_e         state_q, state_d;
  logic [N_DELAY-1:0] sync1_q, sync2_q;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [ACCW-1:0]    acc_q, acc_d, acc_sum;
  logic               bub_q, bub_d, bubble_seen;
  logic [7:0]         result_q, result_d;
  logic               bubble_err_q, bubble_err_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic [CW-1:0]      code;
  logic               bubble;
`ifdef TDC_READER_MINMAX_EN
  logic [CW-1:0]      min_q, min_d, max_q, max_d;
  logic [7:0]         code_min_q, code_min_d, code_max_q, code_max_d;
`endif

  tdc_therm2bin #(.N_DELAY(N_DELAY)) u_therm2bin (
    .taps   (sync2_q),
    .code   (code),
    .bubble (bubble)
  );

  assign acc_sum     = acc_q + ACCW'(code);
  assign bubble_seen = bub_q | bubble;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    bub_d        = bub_q;
    result_d     = result_q;
    bubble_err_d = bubble_err_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
`ifdef TDC_READER_MINMAX_EN
    min_d        = min_q;
    max_d        = max_q;
    code_min_d   = code_min_q;
    code_max_d   = code_max_q;
`endif
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_SYNC;
        cnt_d   = '0;
        acc_d   = '0;
        bub_d   = 1'b0;
        busy_d  = 1'b1;
`ifdef TDC_READER_MINMAX_EN
        min_d   = CW'(N_DELAY);
        max_d   = '0;
`endif
      end
      // Taps seen at the start edge need two more edges to clear the synchronizer.
      ST_SYNC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SYNC_LAST) begin
          state_d = ST_SAMPLE;
          cnt_d   = '0;
        end
      end
      ST_SAMPLE: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = acc_sum;
        bub_d = bubble_seen;
`ifdef TDC_READER_MINMAX_EN
        if (code < min_q) min_d = code;
        if (code > max_q) max_d = code;
`endif
        if (cnt_q == SAMPLE_LAST) begin
          state_d      = ST_DONE;
          result_d     = 8'(acc_sum >> LOG2_SAMPLES);
          bubble_err_d = bubble_seen;
          valid_d      = 1'b1;
          busy_d       = 1'b0;
`ifdef TDC_READER_MINMAX_EN
          code_min_d   = 8'((code < min_q) ? code : min_q);
          code_max_d   = 8'((code > max_q) ? code : max_q);
`endif
        end
      end
      ST_DONE: if (ack) begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      bub_q        <= 1'b0;
      result_q     <= '0;
      bubble_err_q <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
`ifdef TDC_READER_MINMAX_EN
      min_q        <= '0;
      max_q        <= '0;
      code_min_q   <= '0;
      code_max_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= taps;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      bub_q        <= bub_d;
      result_q     <= result_d;
      bubble_err_q <= bubble_err_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
`ifdef TDC_READER_MINMAX_EN
      min_q        <= min_d;
      max_q        <= max_d;
      code_min_q   <= code_min_d;
      code_max_q   <= code_max_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign valid      = valid_q;
  assign result     = result_q;
  assign bubble_err = bubble_err_q;
`ifdef TDC_READER_MINMAX_EN
  assign code_min   = code_min_q;
  assign code_max   = code_max_q;
`endif

endmodule
